servo_spi_master: RTL

//  SPI transmitter driving the servo controller's receive-only SPI port (CPOL=1, CPHA=0,
//  LSB-first bytes). Takes one servo command (channel index + 16-bit pulse width in us)
//  per valid/ready handshake and emits a 3-byte frame: index, pulse[15:8], pulse[7:0].

---
 rtl/servo_spi_master_pkg.sv | 39 +++
 rtl/servo_spi_master_sck_divider.sv | 47 ++++
 rtl/servo_spi_master.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/servo_spi_master_pkg.sv
// -----------------------------------------------------------------------------
// servo_spi_master_pkg
//   Shared definitions for the servo SPI link: frame geometry, the default
//   channel count used by both ends of the link, the transmitter state
//   encoding and small helpers for frame assembly.
// -----------------------------------------------------------------------------
package servo_spi_master_pkg;

   localparam int FRAME_BITS           = 24;
   localparam int BYTE_BITS            = 8;
   localparam int DEFAULT_NUM_CHANNELS = 12;

   localparam logic [4:0] LAST_BIT = 5'(FRAME_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_SHIFT_LO,
      ST_SHIFT_HI,
      ST_BYTE_GAP,
      ST_FRAME_GAP
   } spi_state_t;

   // Frame is shifted out LSB first: index byte, then pulse high byte,
   // then pulse low byte, each byte itself LSB first.
   function automatic logic [FRAME_BITS-1:0] build_frame(
      input logic [7:0]  index,
      input logic [15:0] pulse
   );
      return {pulse[7:0], pulse[15:8], index};
   endfunction

   // True for the last bit of byte 0 and byte 1; the final bit of the
   // frame is excluded because no inter-byte gap follows it.
   function automatic logic is_byte_end(input logic [4:0] bit_idx);
      return (bit_idx[2:0] == 3'(BYTE_BITS - 1)) && (bit_idx != LAST_BIT);
   endfunction

endpackage

// File: rtl/servo_spi_master_sck_divider.sv
// -----------------------------------------------------------------------------
// servo_spi_master_sck_divider
//   Half-period timer for the SPI clock. While i_run is high it counts
//   CLK_DIV system clocks per half period and flags the last cycle of each
//   half period, split by the current SCK level into the strobe that should
//   make SCK rise (currently low) or fall (currently high).
// Ports
//   i_clock        system clock
//   i_reset        synchronous active-high reset
//   i_run          count enable; counter is held at zero while low
//   i_sck_level    current registered SCK level from the FSM
//   o_rise_strobe  last cycle of a low half period
//   o_fall_strobe  last cycle of a high half period
// -----------------------------------------------------------------------------
module servo_spi_master_sck_divider #(
   parameter int CLK_DIV = 4
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_run,
   input  logic i_sck_level,
   output logic o_rise_strobe,
   output logic o_fall_strobe
);

   localparam logic [15:0] HALF_LAST = 16'(CLK_DIV - 1);

   logic [15:0] half_cnt;
   logic        half_done;

   always_comb begin
      half_done     = i_run && (half_cnt == HALF_LAST);
      o_rise_strobe = half_done && !i_sck_level;
      o_fall_strobe = half_done &&  i_sck_level;
   end

   // Restarting at zero on each strobe means every phase that keeps i_run
   // high starts with a fresh full half period.
   always_ff @(posedge i_clock) begin
      if (i_reset || !i_run || half_done) begin
         half_cnt <= '0;
      end else begin
         half_cnt <= half_cnt + 16'd1;
      end
   end

endmodule

// File: rtl/servo_spi_master.sv
// -----------------------------------------------------------------------------
// servo_spi_master
//   SPI transmitter (CPOL=1, CPHA=0, LSB-first bytes) feeding the servo
//   controller's receive-only port. Each accepted command becomes a 3-byte
//   frame: channel index, pulse[15:8], pulse[7:0].
// Ports
//   i_clock         system clock
//   i_reset         synchronous active-high reset
//   i_cmd_valid     command present
//   i_cmd_index     servo channel index (8 bits)
//   i_cmd_pulse     pulse width in us (16 bits)
//   o_cmd_ready     command can be accepted this cycle (IDLE only)
//   o_cmd_rejected  one-cycle pulse after accepting an out-of-range index
//   o_busy          frame in progress or frame gap running
//   o_spi_clock     SCK, idles high
//   o_mosi          serial data, holds the last bit between frames
//   o_select        SS, active low
// -----------------------------------------------------------------------------
module servo_spi_master
   import servo_spi_master_pkg::*;
#(
   parameter int CLK_DIV       = 4,
   parameter int INTERBYTE_GAP = 0,
   parameter int FRAME_GAP     = 4,
   parameter int NUM_CHANNELS  = DEFAULT_NUM_CHANNELS
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_cmd_valid,
   input  logic [7:0]  i_cmd_index,
   input  logic [15:0] i_cmd_pulse,
   output logic        o_cmd_ready,
   output logic        o_cmd_rejected,
   output logic        o_busy,
   output logic        o_spi_clock,
   output logic        o_mosi,
   output logic        o_select
);

   localparam logic [15:0] BYTE_GAP_LAST  = 16'(INTERBYTE_GAP - 1);
   localparam logic [15:0] FRAME_GAP_LAST = 16'(FRAME_GAP - 1);
   localparam logic [8:0]  CHANNEL_LIMIT  = 9'(NUM_CHANNELS);

   spi_state_t            state;
   logic [FRAME_BITS-1:0] shift_reg;
   logic [4:0]            bit_cnt;
   logic [15:0]           gap_cnt;
   logic                  div_run;
   logic                  rise_strobe;
   logic                  fall_strobe;
   logic                  index_bad;

   always_comb begin
      div_run   = (state == ST_SETUP) || (state == ST_SHIFT_LO) || (state == ST_SHIFT_HI);
      index_bad = ({1'b0, i_cmd_index} >= CHANNEL_LIMIT);
   end

   // MOSI is bit 0 of the shift register itself, so it is a flop output,
   // resets to 0 and keeps the final bit once shifting stops.
   assign o_mosi = shift_reg[0];

   servo_spi_master_sck_divider #(
      .CLK_DIV(CLK_DIV)
   ) u_sck_div (
      .i_clock       (i_clock),
      .i_reset       (i_reset),
      .i_run         (div_run),
      .i_sck_level   (o_spi_clock),
      .o_rise_strobe (rise_strobe),
      .o_fall_strobe (fall_strobe)
   );

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state          <= ST_IDLE;
         shift_reg      <= '0;
         bit_cnt        <= '0;
         gap_cnt        <= '0;
         o_cmd_ready    <= 1'b0;
         o_cmd_rejected <= 1'b0;
         o_busy         <= 1'b0;
         o_spi_clock    <= 1'b1;
         o_select       <= 1'b1;
      end else begin
         o_cmd_rejected <= 1'b0;
         case (state)
            ST_IDLE: begin
               o_cmd_ready <= 1'b1;
               if (i_cmd_valid && o_cmd_ready) begin
                  if (index_bad) begin
                     // Consumed but dropped; stays in IDLE and ready.
                     o_cmd_rejected <= 1'b1;
                  end else begin
                     shift_reg   <= build_frame(i_cmd_index, i_cmd_pulse);
                     bit_cnt     <= '0;
                     o_select    <= 1'b0;
                     o_busy      <= 1'b1;
                     o_cmd_ready <= 1'b0;
                     state       <= ST_SETUP;
                  end
               end
            end

            ST_SETUP: begin
               if (fall_strobe) begin
                  o_spi_clock <= 1'b0;
                  state       <= ST_SHIFT_LO;
               end
            end

            ST_SHIFT_LO: begin
               if (rise_strobe) begin
                  o_spi_clock <= 1'b1;
                  state       <= ST_SHIFT_HI;
                  // Next bit appears with the rising edge; the last bit is
                  // left in place so MOSI holds it after the frame.
                  if (bit_cnt != LAST_BIT) begin
                     shift_reg <= shift_reg >> 1;
                  end
               end
            end

            ST_SHIFT_HI: begin
               if (fall_strobe) begin
                  gap_cnt <= '0;
                  if (bit_cnt == LAST_BIT) begin
                     o_select <= 1'b1;
                     if (FRAME_GAP > 0) begin
                        state <= ST_FRAME_GAP;
                     end else begin
                        o_busy      <= 1'b0;
                        o_cmd_ready <= 1'b1;
                        state       <= ST_IDLE;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 5'd1;
                     if ((INTERBYTE_GAP > 0) && is_byte_end(bit_cnt)) begin
                        state <= ST_BYTE_GAP;
                     end else begin
                        o_spi_clock <= 1'b0;
                        state       <= ST_SHIFT_LO;
                     end
                  end
               end
            end

            ST_BYTE_GAP: begin
               // SCK stays high and SS low; the divider is idle and restarts
               // from zero when SHIFT_LO begins.
               if (gap_cnt == BYTE_GAP_LAST) begin
                  o_spi_clock <= 1'b0;
                  state       <= ST_SHIFT_LO;
               end else begin
                  gap_cnt <= gap_cnt + 16'd1;
               end
            end

            ST_FRAME_GAP: begin
               if (gap_cnt == FRAME_GAP_LAST) begin
                  o_busy      <= 1'b0;
                  o_cmd_ready <= 1'b1;
                  state       <= ST_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 16'd1;
               end
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
